// File: rtl/hcm_rmw_pipe.sv
// hcm_rmw_pipe: hit-count-memory RMW engine with full-latency forwarding and clear sweep.
// Define HCM_SATURATE_EN for saturating hit counts; otherwise counts wrap.
module hcm_rmw_pipe #(
  parameter int ROW_BITS  = 10,
  parameter int HITN_BITS = 3,
  parameter int ADDR_BITS = 8,
  parameter int RD_LAT    = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear_req,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [ROW_BITS-1:0]            wr_row,
  input  logic                           wr_new,
  input  logic                           rd_valid,
  output logic                           rd_ready,
  input  logic [ROW_BITS-1:0]            rd_row,
  output logic                           rsp_valid,
  output logic [ROW_BITS-1:0]            rsp_row,
  output logic [ADDR_BITS+HITN_BITS-1:0] rsp_data,
  output logic                           busy,
  output logic [ADDR_BITS:0]             n_alloc,
  output logic                           addr_exhausted
);
  localparam int W = ADDR_BITS + HITN_BITS;
  localparam int DEPTH = 1 << ROW_BITS;

  typedef enum logic [1:0] {IDLE, DRAIN, SWEEP} state_t;
  state_t state, state_nx;

  logic [W-1:0]          mem [DEPTH];
  logic [ROW_BITS-1:0]   sweep_row;
  logic [RD_LAT:0]       pv, pw, pn;
  logic [ROW_BITS-1:0]   prow [RD_LAT+1];
  logic [W-1:0]          pdat [RD_LAT+1];
  logic [RD_LAT-1:0]     hv;
  logic [ROW_BITS-1:0]   hrow [RD_LAT];
  logic [W-1:0]          hdat [RD_LAT];
  logic                  acc_wr, acc_rd, sweeping, alloc_ok, op_we, drop, we;
  logic [ROW_BITS-1:0]   acc_row, waddr;
  logic [W-1:0]          opnd, result, wdata;
  logic [HITN_BITS-1:0]  cnt, cnt_inc;

  assign busy     = state != IDLE;
  assign wr_ready = !busy;
  assign rd_ready = !busy && !wr_valid;
  assign acc_wr   = wr_valid && wr_ready;
  assign acc_rd   = rd_valid && rd_ready;
  assign acc_row  = acc_wr ? wr_row : rd_row;

  // History holds every RAM write since the final-stage op's read, newest at index 0
  always_comb begin
    opnd = pdat[RD_LAT];
    for (int i = RD_LAT - 1; i >= 0; i--)
      if (hv[i] && hrow[i] == prow[RD_LAT]) opnd = hdat[i];
    cnt = opnd[HITN_BITS-1:0];
`ifdef HCM_SATURATE_EN
    cnt_inc = &cnt ? cnt : cnt + 1'b1;
`else
    cnt_inc = cnt + 1'b1;
`endif
    alloc_ok = !n_alloc[ADDR_BITS];
    result   = pn[RD_LAT] ? {n_alloc[ADDR_BITS-1:0], HITN_BITS'(1)} : {opnd[W-1:HITN_BITS], cnt_inc};
    op_we    = pv[RD_LAT] && pw[RD_LAT] && (!pn[RD_LAT] || alloc_ok);
    drop     = pv[RD_LAT] && pw[RD_LAT] && pn[RD_LAT] && !alloc_ok;
    sweeping = state == SWEEP;
    we       = sweeping || op_we;
    waddr    = sweeping ? sweep_row : prow[RD_LAT];
    wdata    = sweeping ? '0 : result;
    state_nx = state == IDLE  ? (clear_req ? DRAIN : IDLE) :
               state == DRAIN ? (|pv ? DRAIN : SWEEP) :
               (&sweep_row ? IDLE : SWEEP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= SWEEP;
      sweep_row      <= '0;
      pv             <= '0;
      hv             <= '0;
      rsp_valid      <= 1'b0;
      rsp_row        <= '0;
      rsp_data       <= '0;
      n_alloc        <= '0;
      addr_exhausted <= 1'b0;
    end else begin
      state <= state_nx;
      if (sweeping) sweep_row <= sweep_row + 1'b1;
      for (int i = RD_LAT; i > 0; i--) pv[i] <= pv[i-1];
      pv[0] <= acc_wr || acc_rd;
      for (int i = RD_LAT - 1; i > 0; i--) hv[i] <= hv[i-1];
      hv[0] <= we;
      rsp_valid <= pv[RD_LAT] && !pw[RD_LAT];
      if (pv[RD_LAT] && !pw[RD_LAT]) begin
        rsp_row  <= prow[RD_LAT];
        rsp_data <= opnd;
      end
      if (sweeping && &sweep_row) begin
        n_alloc        <= '0;
        addr_exhausted <= 1'b0;
      end else begin
        if (op_we && pn[RD_LAT]) n_alloc <= n_alloc + 1'b1;
        if (drop) addr_exhausted <= 1'b1;
      end
    end
  end

  // RAM read is write-first so a write landing on the acceptance edge is seen
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    for (int i = RD_LAT; i > 0; i--) begin
      pw[i]   <= pw[i-1];
      pn[i]   <= pn[i-1];
      prow[i] <= prow[i-1];
      pdat[i] <= pdat[i-1];
    end
    pw[0]   <= acc_wr;
    pn[0]   <= wr_new;
    prow[0] <= acc_row;
    pdat[0] <= (we && waddr == acc_row) ? wdata : mem[acc_row];
    for (int i = RD_LAT - 1; i > 0; i--) begin
      hrow[i] <= hrow[i-1];
      hdat[i] <= hdat[i-1];
    end
    hrow[0] <= waddr;
    hdat[0] <= wdata;
  end
endmodule
